// File: rtl/cr_xp10_decomp_fe_bit_window_pkg.sv
// Shared types and helpers for the XP10 decompressor front-end bit window.
// Holds the aligner word format, the parser-facing window view and the
// byte-count helpers used by the window and its funnel shifter.
package cr_xp10_decomp_fe_bit_window_pkg;

   localparam int FE_WIN_BITS = 64;
   localparam int FE_BUF_BITS = 128;

   // Aligned word from the front-end data aligner; bytes_valid==0 means 8 bytes.
   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  bytes_valid;
      logic        sof;
      logic        eof;
      logic        eob;
   } fe_dp_bus_t;

   // Lookahead view presented to the header/symbol parser.
   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  bits;
      logic        sof;
      logic        eof;
      logic        eob;
   } fe_win_t;

   // Number of valid bits carried by a word with the given bytes_valid.
   function automatic logic [7:0] fe_in_bits(input logic [2:0] bv);
      logic [7:0] n;
      if (bv == 3'd0) begin
         n = 8'd64;
      end else begin
         n = {2'b00, bv, 3'b000};
      end
      return n;
   endfunction

   // Mask keeping only the valid low-order bytes of an aligned word.
   function automatic logic [63:0] fe_byte_mask(input logic [2:0] bv);
      logic [63:0] m;
      case (bv)
         3'd1:    m = 64'h0000_0000_0000_00FF;
         3'd2:    m = 64'h0000_0000_0000_FFFF;
         3'd3:    m = 64'h0000_0000_00FF_FFFF;
         3'd4:    m = 64'h0000_0000_FFFF_FFFF;
         3'd5:    m = 64'h0000_00FF_FFFF_FFFF;
         3'd6:    m = 64'h0000_FFFF_FFFF_FFFF;
         3'd7:    m = 64'h00FF_FFFF_FFFF_FFFF;
         default: m = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/cr_xp10_decomp_fe_bit_shifter.sv
// Combinational 128-bit funnel: drops the consumed low bits of the buffer and
// inserts a masked incoming word right above the bits that remain. Kept as its
// own block so it can be pipelined or exhaustively exercised in isolation.
module cr_xp10_decomp_fe_bit_shifter
   import cr_xp10_decomp_fe_bit_window_pkg::*;
#(
   parameter int BUF_BITS = FE_BUF_BITS,
   parameter int WIN_BITS = FE_WIN_BITS
) (
   input  logic [BUF_BITS-1:0] i_buf,
   input  logic [7:0]          i_take_n,
   input  logic                i_ins_en,
   input  logic [WIN_BITS-1:0] i_ins_data,
   input  logic [2:0]          i_ins_bv,
   input  logic [7:0]          i_ins_ofs,
   output logic [BUF_BITS-1:0] o_buf
);

   logic [WIN_BITS-1:0] w_masked;
   logic [BUF_BITS-1:0] w_ins_wide;
   logic [BUF_BITS-1:0] w_kept;

   // Shift out consumed bits, then OR the masked word in at the fill offset.
   always_comb begin
      w_masked   = i_ins_data & fe_byte_mask(i_ins_bv);
      w_ins_wide = {{(BUF_BITS-WIN_BITS){1'b0}}, w_masked};
      w_kept     = i_buf >> i_take_n;
      if (i_ins_en) begin
         o_buf = w_kept | (w_ins_wide << i_ins_ofs);
      end else begin
         o_buf = w_kept;
      end
   end

endmodule

// File: rtl/cr_xp10_decomp_fe_bit_window.sv
// Front-end bit window: accumulates aligned 64-bit words into a 128-bit
// LSB-first buffer and exposes the oldest 64 bits to the parser. Frame and
// block ends hold off the aligner until the buffer drains so frames never mix.
module cr_xp10_decomp_fe_bit_window
   import cr_xp10_decomp_fe_bit_window_pkg::*;
#(
   parameter int BUF_BITS = FE_BUF_BITS,
   parameter int WIN_BITS = FE_WIN_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  fe_dp_bus_t          i_align_rdata,
   input  logic                i_align_rd,
   output logic                o_align_ack,
   output logic                o_align_clear,
   output logic [WIN_BITS-1:0] o_win_data,
   output logic [7:0]          o_win_bits,
   output logic                o_win_sof,
   output logic                o_win_eof,
   output logic                o_win_eob,
   input  logic                i_win_take,
   input  logic [6:0]          i_win_len,
   input  logic                i_flush,
   output logic                o_frame_done,
   output logic                o_err_underflow
);

   // Architectural state.
   logic [BUF_BITS-1:0] r_buf;
   logic [7:0]          r_bits;
   logic                r_sof;
   logic                r_eof;
   logic                r_eob;
   logic                r_end_pend;
   logic                r_align_clear;
   logic                r_frame_done;
   logic                r_err_underflow;

   // Next-state values.
   logic [BUF_BITS-1:0] w_buf_nxt;
   logic [7:0]          w_bits_nxt;
   logic                w_sof_nxt;
   logic                w_eof_nxt;
   logic                w_eob_nxt;
   logic                w_end_pend_nxt;
   logic                w_align_clear_nxt;
   logic                w_frame_done_nxt;
   logic                w_err_underflow_nxt;

   // Datapath intermediates.
   logic [7:0]          w_len_eff;
   logic [7:0]          w_in_bits;
   logic                w_underflow;
   logic [7:0]          w_take_n;
   logic [7:0]          w_rem;
   logic                w_accept;
   logic [7:0]          w_count_next;
   logic                w_ack;
   logic [BUF_BITS-1:0] w_shift_buf;
   fe_win_t             w_win;

   // Ready toward the aligner depends only on registers and flush, never on
   // align_rd, so no combinational loop forms through the aligner.
   assign w_ack = (r_bits <= 8'(WIN_BITS)) && !r_end_pend && !i_flush;

   // Resolve how many bits are consumed, whether the incoming word is kept,
   // and the resulting fill level.
   always_comb begin
      w_len_eff = (i_win_len == 7'd0) ? 8'd64 : {1'b0, i_win_len};
      w_in_bits = fe_in_bits(i_align_rdata.bytes_valid);
      if (i_win_take) begin
         w_underflow = (w_len_eff > r_bits);
         w_take_n    = w_underflow ? r_bits : w_len_eff;
      end else begin
         w_underflow = 1'b0;
         w_take_n    = 8'd0;
      end
      w_rem = r_bits - w_take_n;
      // An underflow outside a pending end resyncs the aligner, so the word
      // arriving in the same cycle is stale and dropped.
      w_accept = i_align_rd && w_ack && !(w_underflow && !r_end_pend);
      if (w_accept) begin
         w_count_next = w_rem + w_in_bits;
      end else begin
         w_count_next = w_rem;
      end
   end

   cr_xp10_decomp_fe_bit_shifter #(
      .BUF_BITS (BUF_BITS),
      .WIN_BITS (WIN_BITS)
   ) u_shifter (
      .i_buf      (r_buf),
      .i_take_n   (w_take_n),
      .i_ins_en   (w_accept),
      .i_ins_data (i_align_rdata.data),
      .i_ins_bv   (i_align_rdata.bytes_valid),
      .i_ins_ofs  (w_rem),
      .o_buf      (w_shift_buf)
   );

   // Next-state for buffer, flags and event pulses; flush overrides everything.
   always_comb begin
      w_buf_nxt           = r_buf;
      w_bits_nxt          = r_bits;
      w_sof_nxt           = r_sof;
      w_eof_nxt           = r_eof;
      w_eob_nxt           = r_eob;
      w_end_pend_nxt      = r_end_pend;
      w_align_clear_nxt   = 1'b0;
      w_frame_done_nxt    = 1'b0;
      w_err_underflow_nxt = 1'b0;
      if (i_flush) begin
         w_buf_nxt         = '0;
         w_bits_nxt        = 8'd0;
         w_sof_nxt         = 1'b0;
         w_eof_nxt         = 1'b0;
         w_eob_nxt         = 1'b0;
         w_end_pend_nxt    = 1'b0;
         w_align_clear_nxt = 1'b1;
      end else begin
         w_buf_nxt  = w_shift_buf;
         w_bits_nxt = w_count_next;
         // A new frame start only counts if it lands at window bit 0.
         if (w_accept && i_align_rdata.sof && (w_rem == 8'd0)) begin
            w_sof_nxt = 1'b1;
         end else if (w_take_n != 8'd0) begin
            w_sof_nxt = 1'b0;
         end else begin
            w_sof_nxt = r_sof;
         end
         if (w_accept && (i_align_rdata.eof || i_align_rdata.eob)) begin
            w_end_pend_nxt = 1'b1;
            w_eof_nxt      = r_eof | i_align_rdata.eof;
            w_eob_nxt      = r_eob | i_align_rdata.eob;
         end else begin
            w_end_pend_nxt = r_end_pend;
         end
         // Buffer fully drained at a boundary: release the aligner.
         if (r_end_pend && (w_count_next == 8'd0)) begin
            w_end_pend_nxt   = 1'b0;
            w_eof_nxt        = 1'b0;
            w_eob_nxt        = 1'b0;
            w_frame_done_nxt = r_eof;
         end else begin
            w_frame_done_nxt = 1'b0;
         end
         w_err_underflow_nxt = w_underflow;
         w_align_clear_nxt   = w_underflow && !r_end_pend;
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf           <= '0;
         r_bits          <= 8'd0;
         r_sof           <= 1'b0;
         r_eof           <= 1'b0;
         r_eob           <= 1'b0;
         r_end_pend      <= 1'b0;
         r_align_clear   <= 1'b0;
         r_frame_done    <= 1'b0;
         r_err_underflow <= 1'b0;
      end else begin
         r_buf           <= w_buf_nxt;
         r_bits          <= w_bits_nxt;
         r_sof           <= w_sof_nxt;
         r_eof           <= w_eof_nxt;
         r_eob           <= w_eob_nxt;
         r_end_pend      <= w_end_pend_nxt;
         r_align_clear   <= w_align_clear_nxt;
         r_frame_done    <= w_frame_done_nxt;
         r_err_underflow <= w_err_underflow_nxt;
      end
   end

   assign w_win.data = r_buf[WIN_BITS-1:0];
   assign w_win.bits = r_bits;
   assign w_win.sof  = r_sof;
   assign w_win.eof  = r_eof;
   assign w_win.eob  = r_eob;

   assign o_win_data      = w_win.data;
   assign o_win_bits      = w_win.bits;
   assign o_win_sof       = w_win.sof;
   assign o_win_eof       = w_win.eof;
   assign o_win_eob       = w_win.eob;
   assign o_align_ack     = w_ack;
   assign o_align_clear   = r_align_clear;
   assign o_frame_done    = r_frame_done;
   assign o_err_underflow = r_err_underflow;

endmodule

// File: tb/tb_cr_xp10_decomp_fe_bit_window.sv
// Self-checking bench for the front-end bit window: directed boundary cases
// followed by random traffic, all compared against a bit-queue reference.
module tb_cr_xp10_decomp_fe_bit_window;
   import cr_xp10_decomp_fe_bit_window_pkg::*;

   logic        clk;
   logic        rst_n;
   fe_dp_bus_t  i_align_rdata;
   logic        i_align_rd;
   logic        o_align_ack;
   logic        o_align_clear;
   logic [63:0] o_win_data;
   logic [7:0]  o_win_bits;
   logic        o_win_sof;
   logic        o_win_eof;
   logic        o_win_eob;
   logic        i_win_take;
   logic [6:0]  i_win_len;
   logic        i_flush;
   logic        o_frame_done;
   logic        o_err_underflow;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: the buffer as a FIFO of bits, oldest first.
   bit mq[$];
   bit m_sof, m_eof, m_eob, m_pend;
   bit m_fd, m_uf, m_clr;

   cr_xp10_decomp_fe_bit_window dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_align_rdata   (i_align_rdata),
      .i_align_rd      (i_align_rd),
      .o_align_ack     (o_align_ack),
      .o_align_clear   (o_align_clear),
      .o_win_data      (o_win_data),
      .o_win_bits      (o_win_bits),
      .o_win_sof       (o_win_sof),
      .o_win_eof       (o_win_eof),
      .o_win_eob       (o_win_eob),
      .i_win_take      (i_win_take),
      .i_win_len       (i_win_len),
      .i_flush         (i_flush),
      .o_frame_done    (o_frame_done),
      .o_err_underflow (o_err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit model_ready();
      return (mq.size() <= 64) && !m_pend;
   endfunction

   task automatic model_step(input bit rd, input fe_dp_bus_t w, input bit take,
                             input logic [6:0] len, input bit fl);
      int len_e, n, rem, nb;
      bit uf, acc, old_pend, old_eof;
      if (fl) begin
         mq.delete();
         m_sof = 0; m_eof = 0; m_eob = 0; m_pend = 0;
         m_fd = 0; m_uf = 0; m_clr = 1;
      end else begin
         len_e = (len == 7'd0) ? 64 : int'(len);
         uf = take && (len_e > mq.size());
         n = !take ? 0 : (uf ? mq.size() : len_e);
         repeat (n) void'(mq.pop_front());
         rem = mq.size();
         old_pend = m_pend;
         old_eof = m_eof;
         acc = rd && !(uf && !old_pend);
         if (n > 0) m_sof = 0;
         if (acc) begin
            nb = (w.bytes_valid == 3'd0) ? 64 : 8 * int'(w.bytes_valid);
            for (int i = 0; i < nb; i++) mq.push_back(w.data[i]);
            if (w.sof && rem == 0) m_sof = 1;
            if (w.eof || w.eob) begin
               m_pend = 1;
               m_eof = m_eof | w.eof;
               m_eob = m_eob | w.eob;
            end
         end
         m_fd = 0;
         if (old_pend && mq.size() == 0) begin
            m_fd = old_eof;
            m_pend = 0; m_eof = 0; m_eob = 0;
         end
         m_uf = uf;
         m_clr = uf && !old_pend;
      end
   endtask

   task automatic check_outputs();
      logic [63:0] exp;
      for (int i = 0; i < 64; i++) exp[i] = (i < mq.size()) ? mq[i] : 1'b0;
      chk("win_data", o_win_data, exp);
      chk("win_bits", o_win_bits, mq.size());
      chk("win_sof", o_win_sof, m_sof);
      chk("win_eof", o_win_eof, m_eof);
      chk("win_eob", o_win_eob, m_eob);
      chk("frame_done", o_frame_done, m_fd);
      chk("err_underflow", o_err_underflow, m_uf);
      chk("align_clear", o_align_clear, m_clr);
   endtask

   // One clock: drive at negedge, check ready, step model, check state after the edge.
   task automatic cycle(input bit rd, input fe_dp_bus_t w, input bit take,
                        input logic [6:0] len, input bit fl);
      bit rd_eff;
      rd_eff = rd && model_ready();
      @(negedge clk);
      i_align_rd = rd_eff;
      i_align_rdata = w;
      i_win_take = take;
      i_win_len = len;
      i_flush = fl;
      #1;
      chk("align_ack", o_align_ack, model_ready() && !fl);
      model_step(rd_eff, w, take, len, fl);
      @(posedge clk);
      #1;
      check_outputs();
      i_align_rd = 1'b0;
      i_win_take = 1'b0;
      i_flush = 1'b0;
   endtask

   function automatic fe_dp_bus_t mkw(input logic [63:0] d, input logic [2:0] bv,
                                      input bit s, input bit e, input bit b);
      fe_dp_bus_t w;
      w.data = d; w.bytes_valid = bv; w.sof = s; w.eof = e; w.eob = b;
      return w;
   endfunction

   function automatic fe_dp_bus_t rndw();
      return mkw({$urandom, $urandom}, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0);
   endfunction

   fe_dp_bus_t nw;

   initial begin
      nw = mkw(64'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      i_align_rdata = nw;
      i_align_rd = 1'b0;
      i_win_take = 1'b0;
      i_win_len = 7'd0;
      i_flush = 1'b0;
      m_sof = 0; m_eof = 0; m_eob = 0; m_pend = 0; m_fd = 0; m_uf = 0; m_clr = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_outputs();
      chk("rst_ack", o_align_ack, 1'b1);

      // Two full words, no take.
      cycle(1, mkw(64'h0123456789ABCDEF, 3'd0, 0, 0, 0), 0, 7'd0, 0);
      chk("tp1_bits1", o_win_bits, 8'd64);
      cycle(1, mkw(64'hFEDCBA9876543210, 3'd0, 0, 0, 0), 0, 7'd0, 0);
      chk("tp1_bits2", o_win_bits, 8'd128);
      chk("tp1_data2", o_win_data, 64'h0123456789ABCDEF);
      chk("tp1_ack2", o_align_ack, 1'b0);

      // Take 13 per cycle, refilling whenever ready.
      for (int k = 0; k < 12; k++) cycle(1, mkw({$urandom, $urandom}, 3'd0, 0, 0, 0), 1, 7'd13, 0);

      cycle(0, nw, 0, 7'd0, 1);
      chk("tp_flush_bits", o_win_bits, 8'd0);

      // Short eof+sof frame.
      cycle(1, mkw(64'hFFFF_FFFF_FFAB_CDEF, 3'd3, 1, 1, 0), 0, 7'd0, 0);
      chk("tp3_bits", o_win_bits, 8'd24);
      chk("tp3_data", o_win_data, 64'h0000_0000_00AB_CDEF);
      chk("tp3_sof", o_win_sof, 1'b1);
      chk("tp3_eof", o_win_eof, 1'b1);
      chk("tp3_ack", o_align_ack, 1'b0);
      cycle(0, nw, 1, 7'd24, 0);
      chk("tp3_fd", o_frame_done, 1'b1);
      chk("tp3_bits0", o_win_bits, 8'd0);
      chk("tp3_ack1", o_align_ack, 1'b1);
      cycle(0, nw, 0, 7'd0, 0);
      chk("tp3_fd_pulse", o_frame_done, 1'b0);

      // eob-only block of 40 bits.
      cycle(1, mkw(64'h1234_5678_9ABC_DEF0, 3'd5, 0, 0, 1), 0, 7'd0, 0);
      chk("tp4_eob", o_win_eob, 1'b1);
      cycle(0, nw, 1, 7'd40, 0);
      chk("tp4_eob0", o_win_eob, 1'b0);
      chk("tp4_fd", o_frame_done, 1'b0);
      chk("tp4_ack", o_align_ack, 1'b1);

      // Underflow: 10 bits present, ask for 20.
      cycle(1, mkw(64'h0000_0000_0000_5A5A, 3'd2, 0, 0, 0), 0, 7'd0, 0);
      cycle(0, nw, 1, 7'd6, 0);
      chk("tp5_bits10", o_win_bits, 8'd10);
      cycle(0, nw, 1, 7'd20, 0);
      chk("tp5_uf", o_err_underflow, 1'b1);
      chk("tp5_clr", o_align_clear, 1'b1);
      chk("tp5_bits", o_win_bits, 8'd0);
      cycle(0, nw, 0, 7'd0, 0);
      chk("tp5_uf_pulse", o_err_underflow, 1'b0);

      // Flush in the same cycle as append and take.
      cycle(1, mkw(64'hDEAD_BEEF_CAFE_F00D, 3'd0, 1, 0, 0), 0, 7'd0, 0);
      cycle(1, mkw(64'h1111_2222_3333_4444, 3'd0, 0, 1, 0), 1, 7'd10, 1);
      chk("tp6_bits", o_win_bits, 8'd0);
      chk("tp6_data", o_win_data, 64'd0);
      chk("tp6_sof", o_win_sof, 1'b0);
      chk("tp6_clr", o_align_clear, 1'b1);

      // Random traffic.
      for (int k = 0; k < 800; k++) begin
         bit rd, tk, fl;
         logic [6:0] ln;
         rd = $urandom_range(0, 3) != 0;
         tk = $urandom_range(0, 1) == 1;
         fl = $urandom_range(0, 59) == 0;
         ln = ($urandom_range(0, 15) == 0) ? 7'd0 : 7'($urandom_range(1, 64));
         cycle(rd, rndw(), tk, ln, fl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
